inverse_linear: RTL and testbench

Iterative decryption-side transform for the Grasspopper (GOST R 34.12-2015 "Kuznyechik") datapath. It takes one 128-bit block, applies the inverse linear transform L⁻¹ as 16 sequential R⁻¹ steps, then applies the inverse S-box π⁻¹ to every byte, and returns the result. It is the decoder counterpart of the encoder's byte-substitution stage and sits in the decrypt round after round-key XOR. Input and output use valid/ready handshakes.

---
 rtl/inverse_linear.sv | 179 +++++++++++++++++
 tb/tb_inverse_linear.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverse_linear.sv
// rtl/inverse_linear.sv - Kuznyechik decrypt transform: 16 serial R^-1 steps then bytewise pi^-1
`timescale 1ns/1ps
module inverse_linear (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [3:0]     cnt;
  logic [127:0]   w;

  // Coefficients of l() for arguments a14..a0; a15 enters last with coefficient 1.
  localparam logic [7:0] LCOEF [15] = '{8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
                                        8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148};

  // Constant multiply in GF(2^8) mod x^8+x^7+x^6+x+1; c is a constant so this folds to an xtime chain.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return p;
  endfunction

  // One inverse round: shift bytes up, new low byte is l(a14..a0, a15).
  function automatic logic [127:0] r_inv(input logic [127:0] a);
    logic [7:0] acc;
    acc = a[127:120];
    for (int k = 0; k < 15; k++) begin
      acc = acc ^ gf_mul(a[8*(14-k) +: 8], LCOEF[k]);
    end
    return {a[119:0], acc};
  endfunction

  // Inverse of the encoder's pi permutation.
  function automatic logic [7:0] pi_inv(input logic [7:0] x);
    logic [7:0] p;
    p = 8'h00;
    case (x)
      8'h00: p = 8'hA5; 8'h01: p = 8'h2D; 8'h02: p = 8'h32; 8'h03: p = 8'h8F;
      8'h04: p = 8'h0E; 8'h05: p = 8'h30; 8'h06: p = 8'h38; 8'h07: p = 8'hC0;
      8'h08: p = 8'h54; 8'h09: p = 8'hE6; 8'h0A: p = 8'h9E; 8'h0B: p = 8'h39;
      8'h0C: p = 8'h55; 8'h0D: p = 8'h7E; 8'h0E: p = 8'h52; 8'h0F: p = 8'h91;
      8'h10: p = 8'h64; 8'h11: p = 8'h03; 8'h12: p = 8'h57; 8'h13: p = 8'h5A;
      8'h14: p = 8'h1C; 8'h15: p = 8'h60; 8'h16: p = 8'h07; 8'h17: p = 8'h18;
      8'h18: p = 8'h21; 8'h19: p = 8'h72; 8'h1A: p = 8'hA8; 8'h1B: p = 8'hD1;
      8'h1C: p = 8'h29; 8'h1D: p = 8'hC6; 8'h1E: p = 8'hA4; 8'h1F: p = 8'h3F;
      8'h20: p = 8'hE0; 8'h21: p = 8'h27; 8'h22: p = 8'h8D; 8'h23: p = 8'h0C;
      8'h24: p = 8'h82; 8'h25: p = 8'hEA; 8'h26: p = 8'hAE; 8'h27: p = 8'hB4;
      8'h28: p = 8'h9A; 8'h29: p = 8'h63; 8'h2A: p = 8'h49; 8'h2B: p = 8'hE5;
      8'h2C: p = 8'h42; 8'h2D: p = 8'hE4; 8'h2E: p = 8'h15; 8'h2F: p = 8'hB7;
      8'h30: p = 8'hC8; 8'h31: p = 8'h06; 8'h32: p = 8'h70; 8'h33: p = 8'h9D;
      8'h34: p = 8'h41; 8'h35: p = 8'h75; 8'h36: p = 8'h19; 8'h37: p = 8'hC9;
      8'h38: p = 8'hAA; 8'h39: p = 8'hFC; 8'h3A: p = 8'h4D; 8'h3B: p = 8'hBF;
      8'h3C: p = 8'h2A; 8'h3D: p = 8'h73; 8'h3E: p = 8'h84; 8'h3F: p = 8'hD5;
      8'h40: p = 8'hC3; 8'h41: p = 8'hAF; 8'h42: p = 8'h2B; 8'h43: p = 8'h86;
      8'h44: p = 8'hA7; 8'h45: p = 8'hB1; 8'h46: p = 8'hB2; 8'h47: p = 8'h5B;
      8'h48: p = 8'h46; 8'h49: p = 8'hD3; 8'h4A: p = 8'h9F; 8'h4B: p = 8'hFD;
      8'h4C: p = 8'hD4; 8'h4D: p = 8'h0F; 8'h4E: p = 8'h9C; 8'h4F: p = 8'h2F;
      8'h50: p = 8'h9B; 8'h51: p = 8'h43; 8'h52: p = 8'hEF; 8'h53: p = 8'hD9;
      8'h54: p = 8'h79; 8'h55: p = 8'hB6; 8'h56: p = 8'h53; 8'h57: p = 8'h7F;
      8'h58: p = 8'hC1; 8'h59: p = 8'hF0; 8'h5A: p = 8'h23; 8'h5B: p = 8'hE7;
      8'h5C: p = 8'h25; 8'h5D: p = 8'h5E; 8'h5E: p = 8'hB5; 8'h5F: p = 8'h1E;
      8'h60: p = 8'hA2; 8'h61: p = 8'hDF; 8'h62: p = 8'hA6; 8'h63: p = 8'hFE;
      8'h64: p = 8'hAC; 8'h65: p = 8'h22; 8'h66: p = 8'hF9; 8'h67: p = 8'hE2;
      8'h68: p = 8'h4A; 8'h69: p = 8'hBC; 8'h6A: p = 8'h35; 8'h6B: p = 8'hCA;
      8'h6C: p = 8'hEE; 8'h6D: p = 8'h78; 8'h6E: p = 8'h05; 8'h6F: p = 8'h6B;
      8'h70: p = 8'h51; 8'h71: p = 8'hE1; 8'h72: p = 8'h59; 8'h73: p = 8'hA3;
      8'h74: p = 8'hF2; 8'h75: p = 8'h71; 8'h76: p = 8'h56; 8'h77: p = 8'h11;
      8'h78: p = 8'h6A; 8'h79: p = 8'h89; 8'h7A: p = 8'h94; 8'h7B: p = 8'h65;
      8'h7C: p = 8'h8C; 8'h7D: p = 8'hBB; 8'h7E: p = 8'h77; 8'h7F: p = 8'h3C;
      8'h80: p = 8'h7B; 8'h81: p = 8'h28; 8'h82: p = 8'hAB; 8'h83: p = 8'hD2;
      8'h84: p = 8'h31; 8'h85: p = 8'hDE; 8'h86: p = 8'hC4; 8'h87: p = 8'h5F;
      8'h88: p = 8'hCC; 8'h89: p = 8'hCF; 8'h8A: p = 8'h76; 8'h8B: p = 8'h2C;
      8'h8C: p = 8'hB8; 8'h8D: p = 8'hD8; 8'h8E: p = 8'h2E; 8'h8F: p = 8'h36;
      8'h90: p = 8'hDB; 8'h91: p = 8'h69; 8'h92: p = 8'hB3; 8'h93: p = 8'h14;
      8'h94: p = 8'h95; 8'h95: p = 8'hBE; 8'h96: p = 8'h62; 8'h97: p = 8'hA1;
      8'h98: p = 8'h3B; 8'h99: p = 8'h16; 8'h9A: p = 8'h66; 8'h9B: p = 8'hE9;
      8'h9C: p = 8'h5C; 8'h9D: p = 8'h6C; 8'h9E: p = 8'h6D; 8'h9F: p = 8'hAD;
      8'hA0: p = 8'h37; 8'hA1: p = 8'h61; 8'hA2: p = 8'h4B; 8'hA3: p = 8'hB9;
      8'hA4: p = 8'hE3; 8'hA5: p = 8'hBA; 8'hA6: p = 8'hF1; 8'hA7: p = 8'hA0;
      8'hA8: p = 8'h85; 8'hA9: p = 8'h83; 8'hAA: p = 8'hDA; 8'hAB: p = 8'h47;
      8'hAC: p = 8'hC5; 8'hAD: p = 8'hB0; 8'hAE: p = 8'h33; 8'hAF: p = 8'hFA;
      8'hB0: p = 8'h96; 8'hB1: p = 8'h6F; 8'hB2: p = 8'h6E; 8'hB3: p = 8'hC2;
      8'hB4: p = 8'hF6; 8'hB5: p = 8'h50; 8'hB6: p = 8'hFF; 8'hB7: p = 8'h5D;
      8'hB8: p = 8'hA9; 8'hB9: p = 8'h8E; 8'hBA: p = 8'h17; 8'hBB: p = 8'h1B;
      8'hBC: p = 8'h97; 8'hBD: p = 8'h7D; 8'hBE: p = 8'hEC; 8'hBF: p = 8'h58;
      8'hC0: p = 8'hF7; 8'hC1: p = 8'h1F; 8'hC2: p = 8'hFB; 8'hC3: p = 8'h7C;
      8'hC4: p = 8'h09; 8'hC5: p = 8'h0D; 8'hC6: p = 8'h7A; 8'hC7: p = 8'h67;
      8'hC8: p = 8'h45; 8'hC9: p = 8'h87; 8'hCA: p = 8'hDC; 8'hCB: p = 8'hE8;
      8'hCC: p = 8'h4F; 8'hCD: p = 8'h1D; 8'hCE: p = 8'h4E; 8'hCF: p = 8'h04;
      8'hD0: p = 8'hEB; 8'hD1: p = 8'hF8; 8'hD2: p = 8'hF3; 8'hD3: p = 8'h3E;
      8'hD4: p = 8'h3D; 8'hD5: p = 8'hBD; 8'hD6: p = 8'h8A; 8'hD7: p = 8'h88;
      8'hD8: p = 8'hDD; 8'hD9: p = 8'hCD; 8'hDA: p = 8'h0B; 8'hDB: p = 8'h13;
      8'hDC: p = 8'h98; 8'hDD: p = 8'h02; 8'hDE: p = 8'h93; 8'hDF: p = 8'h80;
      8'hE0: p = 8'h90; 8'hE1: p = 8'hD0; 8'hE2: p = 8'h24; 8'hE3: p = 8'h34;
      8'hE4: p = 8'hCB; 8'hE5: p = 8'hED; 8'hE6: p = 8'hF4; 8'hE7: p = 8'hCE;
      8'hE8: p = 8'h99; 8'hE9: p = 8'h10; 8'hEA: p = 8'h44; 8'hEB: p = 8'h40;
      8'hEC: p = 8'h92; 8'hED: p = 8'h3A; 8'hEE: p = 8'h01; 8'hEF: p = 8'h26;
      8'hF0: p = 8'h12; 8'hF1: p = 8'h1A; 8'hF2: p = 8'h48; 8'hF3: p = 8'h68;
      8'hF4: p = 8'hF5; 8'hF5: p = 8'h81; 8'hF6: p = 8'h8B; 8'hF7: p = 8'hC7;
      8'hF8: p = 8'hD6; 8'hF9: p = 8'h20; 8'hFA: p = 8'h0A; 8'hFB: p = 8'h08;
      8'hFC: p = 8'h00; 8'hFD: p = 8'h4C; 8'hFE: p = 8'hD7; 8'hFF: p = 8'h74;
    endcase
    return p;
  endfunction

  function automatic logic [127:0] sub_all(input logic [127:0] a);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = pi_inv(a[8*i +: 8]);
    end
    return r;
  endfunction

  // Handshake flags come from state only; in_ready is also held low during reset.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid)       state_next = CALC;
      CALC: if (cnt == 4'd15)   state_next = SUB;
      SUB:                      state_next = DONE;
      DONE: if (out_ready)      state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Working register, round counter and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w      <= '0;
      cnt    <= 4'd0;
      data_o <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          w   <= data_i;
          cnt <= 4'd0;
        end
        CALC: begin
          w   <= r_inv(w);
          cnt <= cnt + 4'd1;
        end
        SUB:     data_o <= sub_all(w);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_linear.sv
// tb/tb_inverse_linear.sv - self-checking bench for inverse_linear
`timescale 1ns/1ps
module tb_inverse_linear;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_o;

  int checks   = 0;
  int failures = 0;

  inverse_linear dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_i    (data_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_o    (data_o)
  );

  always #5 clk = ~clk;

  // Forward pi of the encoder; the bench derives its inverse from this.
  localparam logic [7:0] PI [256] = '{
    8'hFC,8'hEE,8'hDD,8'h11,8'hCF,8'h6E,8'h31,8'h16,8'hFB,8'hC4,8'hFA,8'hDA,8'h23,8'hC5,8'h04,8'h4D,
    8'hE9,8'h77,8'hF0,8'hDB,8'h93,8'h2E,8'h99,8'hBA,8'h17,8'h36,8'hF1,8'hBB,8'h14,8'hCD,8'h5F,8'hC1,
    8'hF9,8'h18,8'h65,8'h5A,8'hE2,8'h5C,8'hEF,8'h21,8'h81,8'h1C,8'h3C,8'h42,8'h8B,8'h01,8'h8E,8'h4F,
    8'h05,8'h84,8'h02,8'hAE,8'hE3,8'h6A,8'h8F,8'hA0,8'h06,8'h0B,8'hED,8'h98,8'h7F,8'hD4,8'hD3,8'h1F,
    8'hEB,8'h34,8'h2C,8'h51,8'hEA,8'hC8,8'h48,8'hAB,8'hF2,8'h2A,8'h68,8'hA2,8'hFD,8'h3A,8'hCE,8'hCC,
    8'hB5,8'h70,8'h0E,8'h56,8'h08,8'h0C,8'h76,8'h12,8'hBF,8'h72,8'h13,8'h47,8'h9C,8'hB7,8'h5D,8'h87,
    8'h15,8'hA1,8'h96,8'h29,8'h10,8'h7B,8'h9A,8'hC7,8'hF3,8'h91,8'h78,8'h6F,8'h9D,8'h9E,8'hB2,8'hB1,
    8'h32,8'h75,8'h19,8'h3D,8'hFF,8'h35,8'h8A,8'h7E,8'h6D,8'h54,8'hC6,8'h80,8'hC3,8'hBD,8'h0D,8'h57,
    8'hDF,8'hF5,8'h24,8'hA9,8'h3E,8'hA8,8'h43,8'hC9,8'hD7,8'h79,8'hD6,8'hF6,8'h7C,8'h22,8'hB9,8'h03,
    8'hE0,8'h0F,8'hEC,8'hDE,8'h7A,8'h94,8'hB0,8'hBC,8'hDC,8'hE8,8'h28,8'h50,8'h4E,8'h33,8'h0A,8'h4A,
    8'hA7,8'h97,8'h60,8'h73,8'h1E,8'h00,8'h62,8'h44,8'h1A,8'hB8,8'h38,8'h82,8'h64,8'h9F,8'h26,8'h41,
    8'hAD,8'h45,8'h46,8'h92,8'h27,8'h5E,8'h55,8'h2F,8'h8C,8'hA3,8'hA5,8'h7D,8'h69,8'hD5,8'h95,8'h3B,
    8'h07,8'h58,8'hB3,8'h40,8'h86,8'hAC,8'h1D,8'hF7,8'h30,8'h37,8'h6B,8'hE4,8'h88,8'hD9,8'hE7,8'h89,
    8'hE1,8'h1B,8'h83,8'h49,8'h4C,8'h3F,8'hF8,8'hFE,8'h8D,8'h53,8'hAA,8'h90,8'hCA,8'hD8,8'h85,8'h61,
    8'h20,8'h71,8'h67,8'hA4,8'h2D,8'h2B,8'h09,8'h5B,8'hCB,8'h9B,8'h25,8'hD0,8'hBE,8'hE5,8'h6C,8'h52,
    8'h59,8'hA6,8'h74,8'hD2,8'hE6,8'hF4,8'hB4,8'hC0,8'hD1,8'h66,8'hAF,8'hC2,8'h39,8'h4B,8'h63,8'hB6
  };

  localparam logic [7:0] LC [16] = '{8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                                     8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};

  logic [7:0] pinv [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // Forward R and L: a block y encoded with L decodes back to y before pi^-1.
  function automatic logic [127:0] r_fwd(input logic [127:0] a);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < 16; k++) acc = acc ^ gmul(a[8*(15-k) +: 8], LC[k]);
    return {acc, a[127:8]};
  endfunction

  function automatic logic [127:0] l_fwd(input logic [127:0] a);
    logic [127:0] r;
    r = a;
    for (int k = 0; k < 16; k++) r = r_fwd(r);
    return r;
  endfunction

  function automatic logic [127:0] sub_model(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = pinv[a[8*i +: 8]];
    return r;
  endfunction

  task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic accept(input logic [127:0] din);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk_int("accept_wait", int'(n < 50), 1);
    in_valid = 1'b1;
    data_i   = din;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic do_block(input logic [127:0] din, input logic [127:0] req, input string tag);
    int n;
    accept(din);
    wait_out(n);
    chk_int({tag, "_latency"}, n, 17);
    chk128({tag, "_data"}, data_o, req);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_int({tag, "_release"}, int'(out_valid), 0);
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] req;
  } vec_t;

  vec_t         vecs [5];
  logic [127:0] y, req, snap, cur_req;
  logic [127:0] bb_din [3];
  logic [127:0] bb_req [3];
  logic [127:0] expq [$];
  int           acc_at [3];
  int           n, bad, stale, idx, got, cyc, sent, recv;
  logic         acc_now;

  initial begin
    for (int i = 0; i < 256; i++) pinv[PI[i]] = 8'(i);

    vecs[0] = '{128'hd456584dd0e3e84cc3166e4b7fa2890d, 128'hacba95a5a5a5a5a5a5a5a5a5a5a5a5a5};
    vecs[1] = '{128'h0, {16{8'hA5}}};
    vecs[2] = '{128'h79d26221b87b584cd42fbc4ffea5de9a, sub_model(128'hd456584dd0e3e84cc3166e4b7fa2890d)};
    vecs[3] = '{l_fwd({16{8'hFC}}), 128'h0};
    vecs[4] = '{l_fwd({16{8'hEE}}), {16{8'h01}}};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_i = '0;
    repeat (3) @(negedge clk);
    chk_int("rst_in_ready", int'(in_ready), 0);
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk128("rst_data_o", data_o, 128'h0);
    rst = 1'b0;
    #1;
    chk_int("post_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 5; i++) do_block(vecs[i].din, vecs[i].req, $sformatf("vec%0d", i));

    // pi^-1 over every byte value: bytes of the pre-image are pi(x), output must be x
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) begin
        y[8*i +: 8]   = PI[16*j + i];
        req[8*i +: 8] = 8'(16*j + i);
      end
      do_block(l_fwd(y), req, $sformatf("pinv%0d", j));
    end

    // Reset at cycle 5 of a block
    accept(vecs[2].din);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_int("midrst_in_ready", int'(in_ready), 0);
    chk_int("midrst_out_valid", int'(out_valid), 0);
    chk128("midrst_data_o", data_o, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (20) begin @(negedge clk); if (out_valid !== 1'b0) stale++; end
    chk_int("midrst_stale", stale, 0);
    do_block(vecs[0].din, vecs[0].req, "after_rst");

    // Backpressure with a held in_valid
    accept(vecs[4].din);
    wait_out(n);
    chk_int("bp_latency", n, 17);
    snap = data_o;
    in_valid = 1'b1; data_i = vecs[0].din;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_o !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    chk_int("bp_stable", bad, 0);
    chk128("bp_data", data_o, vecs[4].req);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk_int("bp_release", int'(out_valid), 0);
    chk_int("bp_idle_ready", int'(in_ready), 1);
    stale = 0;
    repeat (20) begin @(negedge clk); if (out_valid !== 1'b0) stale++; end
    chk_int("bp_no_take", stale, 0);

    // Back-to-back with in_valid and out_ready held high
    y = 128'h0123456789abcdeffedcba9876543210;
    bb_din[0] = 128'h79d26221b87b584cd42fbc4ffea5de9a;
    bb_req[0] = sub_model(128'hd456584dd0e3e84cc3166e4b7fa2890d);
    bb_din[1] = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
    bb_req[1] = 128'hacba95a5a5a5a5a5a5a5a5a5a5a5a5a5;
    bb_din[2] = l_fwd(y);
    bb_req[2] = sub_model(y);
    for (int i = 0; i < 3; i++) acc_at[i] = 0;
    idx = 0; got = 0; cyc = 0;
    in_valid = 1'b1; data_i = bb_din[0]; out_ready = 1'b1;
    while (got < 3 && cyc < 200) begin
      acc_now = in_valid && in_ready;
      if (acc_now) acc_at[idx] = cyc;
      if (out_valid) begin
        chk128($sformatf("b2b_out%0d", got), data_o, bb_req[got]);
        got++;
      end
      @(negedge clk);
      cyc++;
      if (acc_now) begin
        idx++;
        if (idx < 3) data_i = bb_din[idx];
        else         in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk_int("b2b_count", got, 3);
    chk_int("b2b_gap01", acc_at[1] - acc_at[0], 19);
    chk_int("b2b_gap12", acc_at[2] - acc_at[1], 19);
    @(negedge clk);

    // Random blocks with random stalls on both sides
    sent = 0; recv = 0; cyc = 0; acc_now = 1'b0;
    while (recv < 1000 && cyc < 60000) begin
      if (acc_now) in_valid = 1'b0;
      if (!in_valid && sent < 1000 && $urandom_range(3) != 0) begin
        y        = {$urandom, $urandom, $urandom, $urandom};
        data_i   = l_fwd(y);
        cur_req  = sub_model(y);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(3) != 0);
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        expq.push_back(cur_req);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk_int("rand_extra_output", 1, 0);
        end else begin
          chk128($sformatf("rand_out%0d", recv), data_o, expq.pop_front());
        end
        recv++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk_int("rand_received", recv, 1000);
    chk_int("rand_leftover", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
